// File: rtl/vital_pkg.sv
// Shared types and constants for the vital-signs measurement scheduler.
package vital_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ_T,
    ST_REQ_H,
    ST_REQ_S,
    ST_EVAL
  } state_t;

  localparam int unsigned SNS_T = 0;
  localparam int unsigned SNS_H = 1;
  localparam int unsigned SNS_S = 2;

  typedef logic [7:0] reading_t;

  // One-hot sensor request for a given scheduler state; zero outside REQ_x.
  function automatic logic [2:0] req_onehot(state_t s);
    logic [2:0] r;
    r = 3'b000;
    case (s)
      ST_REQ_T: r[SNS_T] = 1'b1;
      ST_REQ_H: r[SNS_H] = 1'b1;
      ST_REQ_S: r[SNS_S] = 1'b1;
      default:  r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vital_sched_if.sv
// Sensor request/acknowledge handshake shared between scheduler and sensor front end.
interface vital_sched_if;
  import vital_pkg::*;

  logic [2:0] sns_req;
  logic       sns_ack;
  reading_t   sns_data;

  modport master (output sns_req, input sns_ack, input sns_data);
  modport slave  (input sns_req, output sns_ack, output sns_data);
endinterface

// File: rtl/vital_eval.sv
// Combinational round evaluation: limit compares, SpO2 deficit and 2-of-3 vote.
module vital_eval
  import vital_pkg::*;
(
  input  reading_t   temp,
  input  reading_t   hr,
  input  reading_t   spo2,
  input  logic [2:0] valid,
  input  reading_t   temp_lim,
  input  reading_t   hr_lim,
  input  reading_t   spo2_ref,
  input  reading_t   spo2_crit,
  output reading_t   deficit,
  output logic       vote
);

  logic t_hi;
  logic h_hi;
  logic s_lo;

  // Invalid (timed-out) readings never flag abnormal; invalid SpO2 yields no deficit.
  always_comb begin
    t_hi    = valid[SNS_T] && (temp > temp_lim);
    h_hi    = valid[SNS_H] && (hr > hr_lim);
    deficit = '0;
    if (valid[SNS_S] && (spo2 < spo2_ref)) begin
      deficit = spo2_ref - spo2;
    end
    s_lo = deficit > spo2_crit;
    vote = (t_hi & h_hi) | (t_hi & s_lo) | (h_hi & s_lo);
  end

endmodule

// File: rtl/vital_sched.sv
// Vital-signs scheduler: periodic three-sensor rounds, timeout handling,
// persistence filter on the abnormal vote and oxygen-deficit reporting.
//
// state    | meaning
// IDLE     | stopped, waiting for en
// WAIT     | counting SAMPLE_PERIOD cycles between rounds
// REQ_T    | requesting temperature reading
// REQ_H    | requesting heart-rate reading
// REQ_S    | requesting SpO2 reading
// EVAL     | one-cycle evaluation of the captured round
module vital_sched
  import vital_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned ACK_TIMEOUT   = 64,
  parameter int unsigned PERSIST       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  vital_sched_if.master        sns,
  input  reading_t             temp_lim,
  input  reading_t             hr_lim,
  input  reading_t             spo2_ref,
  input  reading_t             spo2_crit,
  output reading_t             o2_dose,
  output logic                 dose_vld,
  output logic                 emerg,
  output logic [2:0]           sns_fault,
  output logic                 busy
);

  localparam logic [15:0] WAIT_LAST   = 16'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]  TO_LOAD     = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  PERSIST_MAX = 4'(PERSIST);

  state_t     state_q,    state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] to_cnt_q,   to_cnt_d;
  reading_t   temp_q,     temp_d;
  reading_t   hr_q,       hr_d;
  reading_t   spo2_q,     spo2_d;
  logic [2:0] valid_q,    valid_d;
  logic [2:0] fault_q,    fault_d;
  logic [3:0] persist_q,  persist_d;
  logic       emerg_q,    emerg_d;
  reading_t   o2_dose_q,  o2_dose_d;
  logic       dose_vld_q, dose_vld_d;

  reading_t   rd_val;
  reading_t   deficit;
  logic       vote;

  vital_eval u_eval (
    .temp      (temp_q),
    .hr        (hr_q),
    .spo2      (spo2_q),
    .valid     (valid_q),
    .temp_lim  (temp_lim),
    .hr_lim    (hr_lim),
    .spo2_ref  (spo2_ref),
    .spo2_crit (spo2_crit),
    .deficit   (deficit),
    .vote      (vote)
  );

  // Next-state and counter logic; the ack timer is a down-counter reloaded on every REQ_x entry.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    temp_d     = temp_q;
    hr_d       = hr_q;
    spo2_d     = spo2_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    persist_d  = persist_q;
    emerg_d    = emerg_q;
    o2_dose_d  = o2_dose_q;
    dose_vld_d = 1'b0;
    rd_val     = sns.sns_ack ? sns.sns_data : '0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d  = ST_REQ_T;
          to_cnt_d = TO_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_REQ_T, ST_REQ_H, ST_REQ_S: begin
        if (sns.sns_ack || (to_cnt_q == '0)) begin
          to_cnt_d = TO_LOAD;
          case (state_q)
            ST_REQ_T: begin
              temp_d         = rd_val;
              valid_d[SNS_T] = sns.sns_ack;
              fault_d[SNS_T] = fault_q[SNS_T] | ~sns.sns_ack;
              state_d        = ST_REQ_H;
            end
            ST_REQ_H: begin
              hr_d           = rd_val;
              valid_d[SNS_H] = sns.sns_ack;
              fault_d[SNS_H] = fault_q[SNS_H] | ~sns.sns_ack;
              state_d        = ST_REQ_S;
            end
            default: begin
              spo2_d         = rd_val;
              valid_d[SNS_S] = sns.sns_ack;
              fault_d[SNS_S] = fault_q[SNS_S] | ~sns.sns_ack;
              state_d        = ST_EVAL;
            end
          endcase
        end else begin
          to_cnt_d = to_cnt_q - 8'd1;
        end
      end
      ST_EVAL: begin
        if (!vote) begin
          persist_d = '0;
        end else if (persist_q != PERSIST_MAX) begin
          persist_d = persist_q + 4'd1;
        end
        emerg_d    = (persist_d == PERSIST_MAX);
        o2_dose_d  = deficit;
        dose_vld_d = 1'b1;
        wait_cnt_d = '0;
        state_d    = en ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      temp_q     <= '0;
      hr_q       <= '0;
      spo2_q     <= '0;
      valid_q    <= '0;
      fault_q    <= '0;
      persist_q  <= '0;
      emerg_q    <= 1'b0;
      o2_dose_q  <= '0;
      dose_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      temp_q     <= temp_d;
      hr_q       <= hr_d;
      spo2_q     <= spo2_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      persist_q  <= persist_d;
      emerg_q    <= emerg_d;
      o2_dose_q  <= o2_dose_d;
      dose_vld_q <= dose_vld_d;
    end
  end

  assign sns.sns_req = req_onehot(state_q);
  assign busy        = (state_q != ST_IDLE);
  assign emerg       = emerg_q;
  assign o2_dose     = o2_dose_q;
  assign dose_vld    = dose_vld_q;
  assign sns_fault   = fault_q;

endmodule

// File: doc/vital_sched.md
VITAL_SCHED -- requirements
Module: vital_sched

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 1000, meaning: cycles spent in WAIT between measurement rounds (range 1..65535).
REQ-002 Parameter ACK_TIMEOUT, default 64, meaning: maximum cycles to wait for a sensor ack (range 1..255).
REQ-003 Parameter PERSIST, default 3, meaning: consecutive abnormal rounds before emergency is raised (range 1..15).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  high: run measurement rounds; low: finish the current round, then idle.
REQ-007 sns_req  output  3  one-hot sensor request; bit0 temperature, bit1 heart rate, bit2 SpO2.
REQ-008 sns_ack  input  1  sensor data-valid acknowledge for the currently requested sensor.
REQ-009 sns_data  input  8  unsigned sensor reading, valid when sns_ack=1.
REQ-010 temp_lim, hr_lim  input  8 each  over-limit thresholds; strict greater-than is abnormal.
REQ-011 spo2_ref, spo2_crit  input  8 each  SpO2 reference level and critical deficit limit.
REQ-012 o2_dose  output  8  registered oxygen deficit of the last round.
REQ-013 dose_vld  output  1  one-cycle pulse when o2_dose updates.
REQ-014 emerg  output  1  emergency flag (level).
REQ-015 sns_fault  output  3  sticky per-sensor timeout flags, same bit order as sns_req.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, REQ_T, REQ_H, REQ_S, EVAL.
REQ-018 IDLE -> WAIT when en=1; the WAIT counter loads 0 on entry.
REQ-019 WAIT -> REQ_T when the counter reaches SAMPLE_PERIOD-1; WAIT -> IDLE if en=0.
REQ-020 REQ_x drives its one-hot sns_req bit every cycle in the state; all other bits are 0.
REQ-021 If sns_ack=1 in a REQ_x cycle, sns_data is captured and the FSM advances (REQ_T -> REQ_H -> REQ_S -> EVAL); sns_req drops the next cycle.
REQ-022 If ACK_TIMEOUT cycles pass without an ack, the FSM sets the matching sns_fault bit, marks that reading invalid, and advances; the timeout counter reloads in each REQ_x state.
REQ-023 An invalid reading never counts as abnormal; an invalid SpO2 reading forces the deficit to 0.
REQ-024 EVAL lasts exactly one cycle and computes: t_hi = temp > temp_lim; h_hi = hr > hr_lim; deficit = spo2_ref - spo2, saturating at 0 when spo2 >= spo2_ref; s_lo = deficit > spo2_crit.
REQ-025 Round result: vote = 1 if at least 2 of {t_hi, h_hi, s_lo} are 1.
REQ-026 The 4-bit persist counter increments (saturating at PERSIST) when vote=1 and clears to 0 when vote=0.
REQ-027 emerg is registered; it is 1 exactly when the persist counter equals PERSIST after the EVAL update, and it changes only on EVAL cycles.
REQ-028 o2_dose loads the deficit, and dose_vld pulses, on the cycle after EVAL.
REQ-029 EVAL -> WAIT if en=1, else -> IDLE; en has no effect inside REQ_x states.
REQ-030 sns_fault bits clear only on reset.

Reset
REQ-031 rst_n=0 immediately forces: FSM IDLE, sns_req=0, o2_dose=0, dose_vld=0, emerg=0, sns_fault=0, busy=0, all counters and captured readings 0.
REQ-032 Reset mid-round discards the partial round; there is no resumption.

Structure
REQ-033 The shared package vital_pkg holds the FSM state enum, the sensor index constants (T=0, H=1, S=2), and the 8-bit reading type.
REQ-034 Sub-module vital_eval is the combinational EVAL logic (threshold compares, saturating subtract, 2-of-3 vote); the FSM and counters stay in vital_sched.

Verification
REQ-035 SAMPLE_PERIOD=4, en=1, immediate acks with temp=40, hr=80, spo2=95; limits 38/100, ref 97, crit 5 -> o2_dose=2, dose_vld one pulse, emerg=0.
REQ-036 temp=40, hr=120, spo2=95, PERSIST=3 -> emerg rises on the 3rd EVAL and not before; one round with hr=80 -> emerg=0 at the next EVAL.
REQ-037 Heart-rate sensor never acks, ACK_TIMEOUT=8 -> sns_fault=3'b010 after 8 cycles in REQ_H, FSM reaches REQ_S, h_hi treated as 0.
REQ-038 spo2=99 with spo2_ref=97 -> o2_dose=0 (saturation), s_lo=0.
REQ-039 Reset asserted during REQ_H with emerg=1 -> all outputs 0 asynchronously; after release with en=1 -> WAIT, then a full new round starting at REQ_T.
REQ-040 en dropped during REQ_T -> the round completes, dose_vld pulses, the FSM goes to IDLE, and busy=0.
